// File: rtl/sobel_edge_detect.sv
// Sobel edge detector on a 3x3 window: L1 gradient magnitude, per-frame
// threshold and border masking, in a fixed four-stage pipeline.
module sobel_edge_detect #(
    parameter logic [11:0] H_DISP = 12'd640,
    parameter logic [11:0] V_DISP = 12'd480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        matrix_vld,
    input  logic [7:0]  matrix_11,
    input  logic [7:0]  matrix_12,
    input  logic [7:0]  matrix_13,
    input  logic [7:0]  matrix_21,
    input  logic [7:0]  matrix_22,
    input  logic [7:0]  matrix_23,
    input  logic [7:0]  matrix_31,
    input  logic [7:0]  matrix_32,
    input  logic [7:0]  matrix_33,
    input  logic [10:0] thresh,
    output logic        dout_vld,
    output logic [7:0]  dout,
    output logic [10:0] grad,
    output logic        frame_end
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned GRAD_W = 11;
    localparam int unsigned POS_W  = 12;
    localparam int unsigned PIPE_D = 4;

    logic [POS_W-1:0]  col_q, col_d, row_q, row_d;
    logic [GRAD_W-1:0] thr_q, thr_d;
    logic [SUM_W-1:0]  gx_p_q, gx_p_d, gx_n_q, gx_n_d;
    logic [SUM_W-1:0]  gy_p_q, gy_p_d, gy_n_q, gy_n_d;
    logic [SUM_W-1:0]  ax_q, ax_d, ay_q, ay_d;
    logic [GRAD_W-1:0] sum_q, sum_d;
    logic [PIPE_D-1:0] vld_q, vld_d;
    logic [PIPE_D-2:0] brd_q, brd_d, last_q, last_d;
    logic [PIX_W-1:0]  dout_q, dout_d;
    logic [GRAD_W-1:0] grad_q, grad_d;
    logic              fe_q, fe_d;
    logic              col_lo_c, col_hi_c, row_lo_c, row_hi_c;
    logic              border_c, last_c;

    assign col_lo_c = (col_q == '0);
    assign col_hi_c = (col_q == H_DISP - 12'd1);
    assign row_lo_c = (row_q == '0);
    assign row_hi_c = (row_q == V_DISP - 12'd1);
    assign border_c = col_lo_c | col_hi_c | row_lo_c | row_hi_c;
    assign last_c   = col_hi_c & row_hi_c;

    // Raster position and per-frame threshold latch
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        thr_d = thr_q;
        if (matrix_vld) begin
            if (col_lo_c && row_lo_c) begin
                thr_d = thresh;
            end
            if (col_hi_c) begin
                col_d = '0;
                row_d = row_hi_c ? '0 : POS_W'(row_q + 12'd1);
            end else begin
                col_d = POS_W'(col_q + 12'd1);
            end
        end
    end

    // Datapath stages S1..S4 plus side-band shift registers
    always_comb begin
        gx_p_d = SUM_W'(matrix_13) + (SUM_W'(matrix_23) << 1) + SUM_W'(matrix_33);
        gx_n_d = SUM_W'(matrix_11) + (SUM_W'(matrix_21) << 1) + SUM_W'(matrix_31);
        gy_p_d = SUM_W'(matrix_31) + (SUM_W'(matrix_32) << 1) + SUM_W'(matrix_33);
        gy_n_d = SUM_W'(matrix_11) + (SUM_W'(matrix_12) << 1) + SUM_W'(matrix_13);

        ax_d = (gx_p_q >= gx_n_q) ? SUM_W'(gx_p_q - gx_n_q) : SUM_W'(gx_n_q - gx_p_q);
        ay_d = (gy_p_q >= gy_n_q) ? SUM_W'(gy_p_q - gy_n_q) : SUM_W'(gy_n_q - gy_p_q);

        sum_d = GRAD_W'(ax_q) + GRAD_W'(ay_q);

        vld_d  = {vld_q[PIPE_D-2:0], matrix_vld};
        brd_d  = {brd_q[PIPE_D-3:0], border_c};
        last_d = {last_q[PIPE_D-3:0], last_c};

        // Output holds the last valid pixel across gaps
        dout_d = dout_q;
        grad_d = grad_q;
        fe_d   = vld_q[PIPE_D-2] & last_q[PIPE_D-2];
        if (vld_q[PIPE_D-2]) begin
            grad_d = brd_q[PIPE_D-2] ? '0 : sum_q;
            dout_d = (!brd_q[PIPE_D-2] && (sum_q >= thr_q)) ? 8'd255 : 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            thr_q  <= 11'd2047;
            gx_p_q <= '0;
            gx_n_q <= '0;
            gy_p_q <= '0;
            gy_n_q <= '0;
            ax_q   <= '0;
            ay_q   <= '0;
            sum_q  <= '0;
            vld_q  <= '0;
            brd_q  <= '0;
            last_q <= '0;
            dout_q <= '0;
            grad_q <= '0;
            fe_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            thr_q  <= thr_d;
            gx_p_q <= gx_p_d;
            gx_n_q <= gx_n_d;
            gy_p_q <= gy_p_d;
            gy_n_q <= gy_n_d;
            ax_q   <= ax_d;
            ay_q   <= ay_d;
            sum_q  <= sum_d;
            vld_q  <= vld_d;
            brd_q  <= brd_d;
            last_q <= last_d;
            dout_q <= dout_d;
            grad_q <= grad_d;
            fe_q   <= fe_d;
        end
    end

    assign dout_vld  = vld_q[PIPE_D-1];
    assign dout      = dout_q;
    assign grad      = grad_q;
    assign frame_end = fe_q;

endmodule
